aes_block_loader: RTL and testbench

- Word-serial input stage that assembles the 128-bit state and the cipher key from a 32-bit word stream.
- Presents them together, registered, to the initial round-key addition stage as a block/roundkey pair with a one-cycle valid pulse.
- Holds the active key across blocks so many blocks can be processed under one key load.
- Sits between the host/bus interface and the round-key addition stage.

---
 rtl/aes_block_loader.sv | 115 +++++++++++
 tb/tb_aes_block_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_loader.sv
// Word-serial loader that assembles an AES state block and cipher key, then hands
// the block with its active key to the initial round-key addition stage.
module aes_block_loader #(
    parameter int unsigned WORD = 32,
    parameter int unsigned NB   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic                 i_sel_key,
    input  logic [WORD-1:0]      i_word,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [WORD*NB-1:0]   o_block,
    output logic [WORD*NB-1:0]   o_roundkey,
    output logic                 o_key_valid
);

    localparam int unsigned BW = WORD * NB;
    localparam int unsigned CW = $clog2(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    typedef enum logic {
        LOAD,
        WAIT_KEY
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   key_cnt, blk_cnt;
    logic [BW-1:0]   key_sr, act_key, blk_sr;
    logic [BW-1:0]   key_full_c, blk_full_c;
    logic            acc_key_c, acc_blk_c;
    logic            key_commit_c, blk_last_c;
    logic            emit_c, emit_held_c;

    // Block words stall while a completed block waits for its first key.
    assign o_ready = rst && ((state_q == LOAD) || i_sel_key);

    // Shadow registers with the incoming word merged into its column.
    always_comb begin
        key_full_c   = key_sr;
        blk_full_c   = blk_sr;
        acc_key_c    = i_valid && o_ready && i_sel_key;
        acc_blk_c    = i_valid && o_ready && !i_sel_key;
        key_commit_c = acc_key_c && (key_cnt == LAST);
        blk_last_c   = acc_blk_c && (blk_cnt == LAST);
        for (int unsigned c = 0; c < NB; c++) begin
            if (key_cnt == CW'(c)) key_full_c[(NB-1-c)*WORD +: WORD] = i_word;
            if (blk_cnt == CW'(c)) blk_full_c[(NB-1-c)*WORD +: WORD] = i_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= LOAD;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        emit_c      = 1'b0;
        emit_held_c = 1'b0;
        case (state_q)
            LOAD: begin
                if (blk_last_c) begin
                    if (o_key_valid) emit_c  = 1'b1;
                    else             state_d = WAIT_KEY;
                end
            end
            WAIT_KEY: begin
                if (key_commit_c) begin
                    state_d     = LOAD;
                    emit_held_c = 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Counters, shadow/active key and the registered output pair.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_cnt     <= '0;
            blk_cnt     <= '0;
            key_sr      <= '0;
            act_key     <= '0;
            blk_sr      <= '0;
            o_valid     <= 1'b0;
            o_block     <= '0;
            o_roundkey  <= '0;
            o_key_valid <= 1'b0;
        end else begin
            o_valid <= emit_c || emit_held_c;
            if (acc_key_c) begin
                key_cnt <= key_commit_c ? '0 : key_cnt + CW'(1);
                key_sr  <= key_full_c;
            end
            if (key_commit_c) begin
                act_key     <= key_full_c;
                o_key_valid <= 1'b1;
            end
            if (acc_blk_c) begin
                blk_cnt <= blk_last_c ? '0 : blk_cnt + CW'(1);
                blk_sr  <= blk_full_c;
            end
            if (emit_c) begin
                o_block    <= blk_full_c;
                o_roundkey <= act_key;
            end else if (emit_held_c) begin
                o_block    <= blk_sr;
                o_roundkey <= key_full_c;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed and random-gap bench for aes_block_loader against a queue-level model
// of block/key assembly and emission.
module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_sel_key = 1'b0;
    logic [31:0]  i_word = '0;
    logic         o_ready, o_valid, o_key_valid;
    logic [127:0] o_block, o_roundkey;

    aes_block_loader #(.WORD(32), .NB(4)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_sel_key(i_sel_key),
        .i_word(i_word), .o_ready(o_ready), .o_valid(o_valid),
        .o_block(o_block), .o_roundkey(o_roundkey), .o_key_valid(o_key_valid)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K3 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] B2 = 128'h00112233445566778899aabbccddeeff;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit mon_on = 1'b0;

    logic [127:0] em_blk[$];
    logic [127:0] em_key[$];
    int           em_cyc[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: words accumulate per stream; a full key replaces the active key,
    // a full block is emitted with the active key or held until the first key.
    logic [127:0] kacc = '0, bacc = '0, held = '0, m_key = '0;
    int           kn = 0, bn = 0;
    bit           m_pend = 0, m_have = 0;
    logic         exp_valid = 0, exp_kv = 0;
    logic [127:0] exp_block = '0, exp_key = '0;

    initial forever begin
        @(posedge clk);
        if (!rst) begin
            kn = 0; bn = 0; m_pend = 0; m_have = 0; m_key = '0;
            exp_valid = 0; exp_block = '0; exp_key = '0; exp_kv = 0;
        end else begin
            exp_valid = 0;
            if (i_valid && (!m_pend || i_sel_key)) begin
                if (i_sel_key) begin
                    kacc = {kacc[95:0], i_word};
                    kn++;
                    if (kn == 4) begin
                        kn = 0; m_key = kacc; m_have = 1; exp_kv = 1;
                        if (m_pend) begin
                            m_pend = 0; exp_valid = 1; exp_block = held; exp_key = m_key;
                        end
                    end
                end else begin
                    bacc = {bacc[95:0], i_word};
                    bn++;
                    if (bn == 4) begin
                        bn = 0;
                        if (m_have) begin
                            exp_valid = 1; exp_block = bacc; exp_key = m_key;
                        end else begin
                            held = bacc; m_pend = 1;
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare every cycle once reset has been applied.
    initial begin : monitor
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("o_ready", 128'(o_ready), 128'(rst && (!m_pend || i_sel_key)));
                chk("o_valid", 128'(o_valid), 128'(exp_valid));
                chk("o_key_valid", 128'(o_key_valid), 128'(exp_kv));
                chk("o_block", o_block, exp_block);
                chk("o_roundkey", o_roundkey, exp_key);
                if (o_valid && prev_v) chk("o_valid_back_to_back", 128'(1), 128'(0));
                prev_v = o_valid;
                if (o_valid) begin
                    em_blk.push_back(o_block);
                    em_key.push_back(o_roundkey);
                    em_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic [31:0] w, output logic acc);
        i_valid = v; i_sel_key = s; i_word = w;
        @(negedge clk);
        acc = v && o_ready;
        last_cyc = cyc;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic put(input logic s, input logic [31:0] w);
        logic acc;
        for (int t = 0; t < 64; t++) begin
            drive(1'b1, s, w, acc);
            if (acc) return;
        end
        chk("put_timeout", 128'(1), 128'(0));
    endtask

    task automatic put_words(input logic s, input logic [127:0] v, input int first, input int last);
        for (int i = first; i <= last; i++) put(s, v[127-32*i -: 32]);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, acc);
    endtask

    task automatic do_reset();
        rst = 1'b0; i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic chk_em(input string nm, input int idx, input logic [127:0] b, input logic [127:0] k);
        if (em_blk.size() <= idx) begin
            chk({nm, "_missing"}, 128'(em_blk.size()), 128'(idx + 1));
        end else begin
            chk({nm, "_block"}, em_blk[idx], b);
            chk({nm, "_key"}, em_key[idx], k);
        end
    endtask

    initial begin
        logic acc;
        int   n0, kidx, bidx, blocks;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        chk("reset_o_valid", 128'(o_valid), 128'(0));
        chk("reset_o_block", o_block, 128'(0));
        chk("reset_o_roundkey", o_roundkey, 128'(0));
        chk("reset_o_key_valid", 128'(o_key_valid), 128'(0));
        chk("reset_o_ready", 128'(o_ready), 128'(1));
        @(posedge clk); #1;

        // FIPS-197 vector, no stalls.
        put_words(1'b1, K1, 0, 3);
        put_words(1'b0, B1, 0, 3);
        n0 = last_cyc;
        idle(2);
        chk_em("fips", 0, B1, K1);
        if (em_cyc.size() > 0) chk("fips_latency", 128'(em_cyc[0] - n0), 128'(1));
        if (em_blk.size() > 0)
            chk("fips_addroundkey", em_blk[0] ^ em_key[0], 128'h193de3bea0f4e22b9ac68d2ae9f84808);

        // Block before key: stall, then emit with the new key.
        do_reset();
        put_words(1'b0, B1, 0, 3);
        drive(1'b1, 1'b0, B2[127:96], acc);
        chk("stall_1", 128'(acc), 128'(0));
        drive(1'b1, 1'b0, B2[127:96], acc);
        chk("stall_2", 128'(acc), 128'(0));
        chk("stall_no_emit", 128'(em_blk.size()), 128'(1));
        put_words(1'b1, K1, 0, 3);
        n0 = last_cyc;
        put_words(1'b0, B2, 0, 3);
        idle(2);
        chk_em("held", 1, B1, K1);
        if (em_cyc.size() > 1) chk("held_latency", 128'(em_cyc[1] - n0), 128'(1));
        chk_em("after_held", 2, B2, K1);

        // Key reuse across three back-to-back blocks.
        put_words(1'b0, B2, 0, 3);
        put_words(1'b0, B1, 0, 3);
        put_words(1'b0, B2, 0, 3);
        idle(2);
        chk_em("reuse0", 3, B2, K1);
        chk_em("reuse1", 4, B1, K1);
        chk_em("reuse2", 5, B2, K1);
        if (em_cyc.size() > 5) begin
            chk("reuse_gap1", 128'(em_cyc[4] - em_cyc[3]), 128'(4));
            chk("reuse_gap2", 128'(em_cyc[5] - em_cyc[4]), 128'(4));
        end

        // Key commit mid-block applies to that block.
        put_words(1'b0, B2, 0, 1);
        put_words(1'b1, K2, 0, 3);
        put_words(1'b0, B2, 2, 3);
        idle(2);
        chk_em("interleave", 6, B2, K2);

        // Key commit after the block's last word applies to the next block.
        put_words(1'b0, B1, 0, 1);
        put_words(1'b1, K3, 0, 2);
        put_words(1'b0, B1, 2, 3);
        put_words(1'b1, K3, 3, 3);
        put_words(1'b0, B2, 0, 3);
        idle(2);
        chk_em("late_key_old", 7, B1, K2);
        chk_em("late_key_next", 8, B2, K3);

        // Mid-operation reset drops everything, including the active key.
        put_words(1'b1, K1, 0, 1);
        put_words(1'b0, B1, 0, 2);
        do_reset();
        @(negedge clk);
        chk("midrst_o_valid", 128'(o_valid), 128'(0));
        chk("midrst_o_block", o_block, 128'(0));
        chk("midrst_o_roundkey", o_roundkey, 128'(0));
        chk("midrst_o_key_valid", 128'(o_key_valid), 128'(0));
        @(posedge clk); #1;
        put_words(1'b0, B2, 0, 3);
        idle(3);
        chk("midrst_no_emit", 128'(em_blk.size()), 128'(9));
        drive(1'b1, 1'b0, 32'h12345678, acc);
        chk("midrst_stall", 128'(acc), 128'(0));
        put_words(1'b1, K2, 0, 3);
        idle(2);
        chk_em("midrst_held", 9, B2, K2);

        // Random gaps and interleaved key updates over 100 blocks.
        n0 = em_blk.size();
        kidx = 0; bidx = 0; blocks = 0;
        for (int t = 0; t < 20000 && blocks < 100; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, $urandom_range(0, 1) == 1, $urandom, acc);
            end else if ($urandom_range(0, 9) == 0) begin
                drive(1'b1, 1'b1, $urandom, acc);
                if (acc) kidx = (kidx + 1) % 4;
            end else begin
                drive(1'b1, 1'b0, $urandom, acc);
                if (acc) begin
                    bidx++;
                    if (bidx == 4) begin
                        bidx = 0;
                        blocks++;
                    end
                end
            end
        end
        idle(3);
        chk("random_blocks", 128'(blocks), 128'(100));
        chk("random_emissions", 128'(em_blk.size() - n0), 128'(100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
